// File: rtl/branch_pc_if.sv
// Execute-stage control/compare bus between the ALU/decoder and the PC unit.
//   master : drives stall, valid, branch/jal/jalr, funct3, imm, alu_result and the compare
//            flags; observes pc, pc_plus4, flush and misaligned.
//   slave  : the PC unit; the reverse directions.
// Optional: BRANCH_PC_STATS_EN adds branch_count and taken_count (32 bit, slave -> master).
interface branch_pc_if #(
  parameter int unsigned BITS = 64
);
  logic            stall;
  logic            valid;
  logic            branch;
  logic            jal;
  logic            jalr;
  logic [2:0]      funct3;
  logic [BITS-1:0] imm;
  logic [BITS-1:0] alu_result;
  logic            flag_igual;
  logic            flag_menor;
  logic            flag_maior_igual_u;
  logic [BITS-1:0] pc;
  logic [BITS-1:0] pc_plus4;
  logic            flush;
  logic            misaligned;
`ifdef BRANCH_PC_STATS_EN
  logic [31:0]     branch_count;
  logic [31:0]     taken_count;
`endif

  modport master (
    output stall, valid, branch, jal, jalr, funct3, imm, alu_result,
    output flag_igual, flag_menor, flag_maior_igual_u,
`ifdef BRANCH_PC_STATS_EN
    input  branch_count, taken_count,
`endif
    input  pc, pc_plus4, flush, misaligned
  );

  modport slave (
    input  stall, valid, branch, jal, jalr, funct3, imm, alu_result,
    input  flag_igual, flag_menor, flag_maior_igual_u,
`ifdef BRANCH_PC_STATS_EN
    output branch_count, taken_count,
`endif
    output pc, pc_plus4, flush, misaligned
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Program-counter owner and branch resolver for the execute stage.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset (overrides everything, including stall)
//   bus   : branch_pc_if.slave -- control bits, funct3, imm, ALU sum and compare flags in;
//           registered pc, combinational pc_plus4, one-cycle flush and misaligned out.
// A redirect (taken branch, JAL, JALR) loads the new PC and raises flush for one cycle; the
// following cycle is a bubble (FLUSH) whose instruction is wrong-path and ignored. A target
// with bit 1 set traps to TRAP_VECTOR instead.
// Optional: define BRANCH_PC_STATS_EN for saturating branch/taken counters.
module branch_pc_unit #(
  parameter int unsigned     BITS         = 64,
  parameter logic [BITS-1:0] RESET_VECTOR = '0,
  parameter logic [BITS-1:0] TRAP_VECTOR  = BITS'(64'h100)
) (
  input logic        clk,
  input logic        reset,
  branch_pc_if.slave bus
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e          state_q;
  logic [BITS-1:0] pc_q;
  logic            flush_q;
  logic            misaligned_q;

  logic            cond_true;
  logic            redirect;
  logic            misalign;
  logic            branch_accept;
  logic [BITS-1:0] target;
  logic [BITS-1:0] pc_plus4;

  // JALR clears bit 0 of the sum, so that bit is never consumed.
  logic unused_alu_lsb;
  assign unused_alu_lsb = bus.alu_result[0];

  assign pc_plus4 = pc_q + BITS'(4);

  always_comb begin
    cond_true = 1'b0;
    case (bus.funct3)
      3'b000:  cond_true = bus.flag_igual;
      3'b001:  cond_true = ~bus.flag_igual;
      3'b100:  cond_true = bus.flag_menor;
      3'b101:  cond_true = ~bus.flag_menor;
      3'b110:  cond_true = ~bus.flag_maior_igual_u;
      3'b111:  cond_true = bus.flag_maior_igual_u;
      default: cond_true = 1'b0;
    endcase
  end

  // Control priority jalr > jal > branch; only instructions in RUN are eligible.
  always_comb begin
    redirect      = 1'b0;
    branch_accept = 1'b0;
    target        = pc_q + bus.imm;
    if (state_q == StRun && bus.valid) begin
      if (bus.jalr) begin
        redirect = 1'b1;
        target   = {bus.alu_result[BITS-1:1], 1'b0};
      end else if (bus.jal) begin
        redirect = 1'b1;
      end else if (bus.branch) begin
        branch_accept = 1'b1;
        redirect      = cond_true;
      end
    end
    misalign = redirect & target[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      pc_q         <= RESET_VECTOR;
      flush_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (bus.stall) begin
      // Hold PC and state; a pending flush is dropped, not reissued.
      flush_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (misalign) begin
            pc_q         <= TRAP_VECTOR;
            flush_q      <= 1'b1;
            misaligned_q <= 1'b1;
            state_q      <= StFlush;
          end else if (redirect) begin
            pc_q         <= target;
            flush_q      <= 1'b1;
            misaligned_q <= 1'b0;
            state_q      <= StFlush;
          end else begin
            pc_q         <= pc_plus4;
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;
          end
        end
        StFlush: begin
          pc_q         <= pc_plus4;
          flush_q      <= 1'b0;
          misaligned_q <= 1'b0;
          state_q      <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.flush      = flush_q;
  assign bus.misaligned = misaligned_q;

`ifdef BRANCH_PC_STATS_EN
  logic [31:0] branch_count_q;
  logic [31:0] taken_count_q;

  // Taken count includes branches that trap on a misaligned target.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else if (!bus.stall && branch_accept) begin
      if (branch_count_q != 32'hFFFF_FFFF) begin
        branch_count_q <= branch_count_q + 32'd1;
      end
      if (cond_true && taken_count_q != 32'hFFFF_FFFF) begin
        taken_count_q <= taken_count_q + 32'd1;
      end
    end
  end

  assign bus.branch_count = branch_count_q;
  assign bus.taken_count  = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  branch_pc_if #(.BITS(64)) bus ();

  branch_pc_unit #(.BITS(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic        valid;
    logic [2:0]  ctl;    // {jalr, jal, branch}
    logic [2:0]  f3;
    logic [63:0] imm;
    logic [63:0] alu;
    logic [2:0]  flags;  // {igual, menor, maior_igual_u}
    logic [63:0] epc;
    logic        efl;
    logic        emis;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic        fl;
    logic        mis;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(string name, logic rst, logic stall, logic valid, logic [2:0] ctl,
                              logic [2:0] f3, logic [63:0] imm, logic [63:0] alu,
                              logic [2:0] flags, logic [63:0] epc, logic efl, logic emis);
    vec_t v;
    v.name = name; v.rst = rst; v.stall = stall; v.valid = valid; v.ctl = ctl; v.f3 = f3;
    v.imm = imm; v.alu = alu; v.flags = flags; v.epc = epc; v.efl = efl; v.emis = emis;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one vector, push its expectation, let one edge pass, pop and compare.
  task automatic apply(vec_t v);
    exp_t e;
    reset                  = v.rst;
    bus.stall              = v.stall;
    bus.valid              = v.valid;
    {bus.jalr, bus.jal, bus.branch} = v.ctl;
    bus.funct3             = v.f3;
    bus.imm                = v.imm;
    bus.alu_result         = v.alu;
    {bus.flag_igual, bus.flag_menor, bus.flag_maior_igual_u} = v.flags;
    exp_q.push_back('{name: v.name, pc: v.epc, fl: v.efl, mis: v.emis});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.name, ".pc"}, bus.pc, e.pc);
    chk({e.name, ".pc_plus4"}, bus.pc_plus4, e.pc + 64'd4);
    chk({e.name, ".flush"}, {63'd0, bus.flush}, {63'd0, e.fl});
    chk({e.name, ".misaligned"}, {63'd0, bus.misaligned}, {63'd0, e.mis});
  endtask

  localparam logic [2:0] NONE = 3'b000, BR = 3'b001, JAL = 3'b010, JALR = 3'b100;

  initial begin
    // Reset for two cycles, with stall high to show reset wins.
    vecs.push_back(mk("rst0",      1, 1, 0, NONE, 0, 0, 0, 0, 64'h0, 0, 0));
    vecs.push_back(mk("rst1",      1, 0, 1, JAL,  0, 64'h40, 0, 0, 64'h0, 0, 0));
    vecs.push_back(mk("idle4",     0, 0, 0, NONE, 0, 0, 0, 0, 64'h4, 0, 0));
    vecs.push_back(mk("idle8",     0, 0, 0, NONE, 0, 0, 0, 0, 64'h8, 0, 0));
    vecs.push_back(mk("idle12",    0, 0, 0, NONE, 0, 0, 0, 0, 64'hC, 0, 0));
    vecs.push_back(mk("jal_to1c",  0, 0, 1, JAL,  0, 64'h10, 0, 0, 64'h1C, 1, 0));
    vecs.push_back(mk("bubble20",  0, 0, 0, NONE, 0, 0, 0, 0, 64'h20, 0, 0));
    vecs.push_back(mk("beq_tk",    0, 0, 1, BR,   3'b000, 64'h40, 0, 3'b100, 64'h60, 1, 0));
    vecs.push_back(mk("beq_inflush", 0, 0, 1, BR, 3'b000, 64'h40, 0, 3'b100, 64'h64, 0, 0));
    vecs.push_back(mk("bltu_tk",   0, 0, 1, BR,   3'b110, 64'h100, 0, 3'b000, 64'h164, 1, 0));
    vecs.push_back(mk("bubble168", 0, 0, 0, NONE, 0, 0, 0, 0, 64'h168, 0, 0));
    vecs.push_back(mk("bge_nt",    0, 0, 1, BR,   3'b101, 64'h100, 0, 3'b010, 64'h16C, 0, 0));
    vecs.push_back(mk("f3_010",    0, 0, 1, BR,   3'b010, 64'h100, 0, 3'b111, 64'h170, 0, 0));
    vecs.push_back(mk("f3_011",    0, 0, 1, BR,   3'b011, 64'h100, 0, 3'b111, 64'h174, 0, 0));
    vecs.push_back(mk("bne_nt",    0, 0, 1, BR,   3'b001, 64'h100, 0, 3'b100, 64'h178, 0, 0));
    vecs.push_back(mk("blt_back",  0, 0, 1, BR,   3'b100, -64'sd8, 0, 3'b010, 64'h170, 1, 0));
    vecs.push_back(mk("bubble174", 0, 0, 0, NONE, 0, 0, 0, 0, 64'h174, 0, 0));
    vecs.push_back(mk("jalr_prio", 0, 0, 1, JALR | JAL | BR, 3'b000, 64'h8, 64'h1235, 3'b100,
                      64'h1234, 1, 0));
    vecs.push_back(mk("bubble1238", 0, 0, 0, NONE, 0, 0, 0, 0, 64'h1238, 0, 0));
    vecs.push_back(mk("jalr_mis",  0, 0, 1, JALR, 0, 0, 64'h1236, 0, 64'h100, 1, 1));
    vecs.push_back(mk("bubble104", 0, 0, 0, NONE, 0, 0, 0, 0, 64'h104, 0, 0));
    vecs.push_back(mk("bgeu_mis",  0, 0, 1, BR,   3'b111, 64'h2, 0, 3'b001, 64'h100, 1, 1));
    vecs.push_back(mk("bubble104b", 0, 0, 0, NONE, 0, 0, 0, 0, 64'h104, 0, 0));
    vecs.push_back(mk("invalid_br", 0, 0, 0, BR,  3'b000, 64'h40, 0, 3'b100, 64'h108, 0, 0));
    vecs.push_back(mk("stall_jal", 0, 1, 1, JAL,  0, 64'h40, 0, 0, 64'h108, 0, 0));
    vecs.push_back(mk("jalr_top",  0, 0, 1, JALR, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0,
                      64'hFFFF_FFFF_FFFF_FFF8, 1, 0));
    vecs.push_back(mk("bubble_top", 0, 0, 0, NONE, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0));
    vecs.push_back(mk("stall_top", 0, 1, 1, JAL,  0, 64'h40, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0));
    vecs.push_back(mk("wrap",      0, 0, 0, NONE, 0, 0, 0, 0, 64'h0, 0, 0));
    vecs.push_back(mk("jal_to20",  0, 0, 1, JAL,  0, 64'h20, 0, 0, 64'h20, 1, 0));
    vecs.push_back(mk("stall_inflush", 0, 1, 1, JAL, 0, 64'h40, 0, 0, 64'h20, 0, 0));
    vecs.push_back(mk("flush_ign_jal", 0, 0, 1, JAL, 0, 64'h40, 0, 0, 64'h24, 0, 0));
    vecs.push_back(mk("jal_run",   0, 0, 1, JAL,  0, 64'h40, 0, 0, 64'h64, 1, 0));
    // Reset while in FLUSH returns to RUN: the next jal redirects immediately.
    vecs.push_back(mk("rst_inflush", 1, 0, 1, JAL, 0, 64'h40, 0, 0, 64'h0, 0, 0));
    vecs.push_back(mk("jal_after_rst", 0, 0, 1, JAL, 0, 64'h40, 0, 0, 64'h40, 1, 0));
    // Counter sequence: 5 accepted branches, 3 taken (one of them traps), plus noise.
    vecs.push_back(mk("s_rst",     1, 0, 0, NONE, 0, 0, 0, 0, 64'h0, 0, 0));
    vecs.push_back(mk("s_beq",     0, 0, 1, BR,   3'b000, 64'h40, 0, 3'b100, 64'h40, 1, 0));
    vecs.push_back(mk("s_bub0",    0, 0, 1, BR,   3'b000, 64'h40, 0, 3'b100, 64'h44, 0, 0));
    vecs.push_back(mk("s_bne",     0, 0, 1, BR,   3'b001, 64'h40, 0, 3'b100, 64'h48, 0, 0));
    vecs.push_back(mk("s_blt",     0, 0, 1, BR,   3'b100, 64'h10, 0, 3'b010, 64'h58, 1, 0));
    vecs.push_back(mk("s_bub1",    0, 0, 0, NONE, 0, 0, 0, 0, 64'h5C, 0, 0));
    vecs.push_back(mk("s_bltu",    0, 0, 1, BR,   3'b110, 64'h10, 0, 3'b001, 64'h60, 0, 0));
    vecs.push_back(mk("s_bgeu",    0, 0, 1, BR,   3'b111, 64'h2, 0, 3'b001, 64'h100, 1, 1));
    vecs.push_back(mk("s_bub2",    0, 0, 0, NONE, 0, 0, 0, 0, 64'h104, 0, 0));
    vecs.push_back(mk("s_jal",     0, 0, 1, JAL,  0, 64'h10, 0, 0, 64'h114, 1, 0));
    vecs.push_back(mk("s_bub3",    0, 0, 0, NONE, 0, 0, 0, 0, 64'h118, 0, 0));
    vecs.push_back(mk("s_stall_br", 0, 1, 1, BR,  3'b000, 64'h40, 0, 3'b100, 64'h118, 0, 0));
    vecs.push_back(mk("s_inval_br", 0, 0, 0, BR,  3'b000, 64'h40, 0, 3'b100, 64'h11C, 0, 0));

    reset = 1'b1;
    bus.stall = 1'b0; bus.valid = 1'b0; bus.branch = 1'b0; bus.jal = 1'b0; bus.jalr = 1'b0;
    bus.funct3 = '0; bus.imm = '0; bus.alu_result = '0;
    bus.flag_igual = 1'b0; bus.flag_menor = 1'b0; bus.flag_maior_igual_u = 1'b0;
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

`ifdef BRANCH_PC_STATS_EN
    chk("branch_count", {32'd0, bus.branch_count}, 64'd5);
    chk("taken_count", {32'd0, bus.taken_count}, 64'd3);
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Program-counter owner and branch resolver; the consumer end of the ALU compare interface.
- Takes the ALU compare flags (flag_igual, flag_menor, flag_maior_igual_u) and the ALU sum (jalr target = rs1+imm) for the instruction in execute.
- Decides BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR, holds the registered PC and emits a one-cycle flush on redirect.
- Sits between the ALU and instruction fetch.

Parameters:
- BITS, 64, datapath/PC width.
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 64'h100, PC value loaded on a misaligned target.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all state this cycle
- valid  in  1  execute-stage instruction is valid
- branch  in  1  conditional branch in execute
- jal  in  1  JAL in execute
- jalr  in  1  JALR in execute
- funct3  in  3  branch condition code
- imm  in  BITS  sign-extended branch/JAL offset
- alu_result  in  BITS  ALU sum, the JALR target
- flag_igual  in  1  dina == dinb
- flag_menor  in  1  dina < dinb, signed
- flag_maior_igual_u  in  1  dina >= dinb, unsigned
- pc  out  BITS  current registered PC
- pc_plus4  out  BITS  pc+4, combinational, modulo 2^BITS
- flush  out  1  registered; high one cycle after a redirect
- misaligned  out  1  registered; high one cycle after a misaligned target

Behaviour:
- Reset (synchronous, active-high): pc=RESET_VECTOR, flush=0, misaligned=0, state=RUN, counters=0. Reset overrides stall and all inputs.
- States:
  - RUN: instructions accepted.
  - FLUSH: one bubble cycle. valid is ignored because that instruction is wrong-path.
- Condition decode from funct3:
  - 000 taken if flag_igual (BEQ)
  - 001 taken if !flag_igual (BNE)
  - 100 taken if flag_menor (BLT)
  - 101 taken if !flag_menor (BGE)
  - 110 taken if !flag_maior_igual_u (BLTU)
  - 111 taken if flag_maior_igual_u (BGEU)
  - 010/011 never taken
- Redirect request exists in RUN when valid and any of the following hold. If several control bits are set, priority is jalr > jal > branch.
  - jalr: target = {alu_result[BITS-1:1],1'b0}.
  - jal: target = pc+imm, modulo 2^BITS.
  - branch && condition true: target = pc+imm.
- Misaligned check: target[1]==1 is misaligned (no compressed ISA).
- Per-cycle priority (evaluated at the clock edge): reset > stall > misaligned > redirect > sequential.
  - stall: pc, state and counters hold; flush and misaligned drive 0.
  - misaligned: pc<=TRAP_VECTOR, misaligned<=1, flush<=1, state<=FLUSH.
  - redirect: pc<=target, flush<=1, state<=FLUSH.
  - sequential, RUN with no redirect: pc<=pc+4, flush<=0. Wraps from all-ones region to low addresses modulo 2^BITS.
  - FLUSH without stall: pc<=pc+4, flush<=0, state<=RUN. Redirect inputs are ignored in this state.
- Latency: decision on edge N; new pc and flush both visible after edge N. Fetch discards exactly one instruction.
- Not-taken branch and valid=0 in RUN both behave as sequential.
- Stall asserted in FLUSH: remains in FLUSH; flush output reads 0 while stalled and is not reissued.

Optional Feature:
- Macro: BRANCH_PC_STATS_EN.
- Defined:
  - Adds outputs branch_count (32) and taken_count (32), both reset to 0.
  - branch_count increments on every accepted (RUN, valid, !stall) branch.
  - taken_count increments on every accepted branch whose condition is true, including ones that trap as misaligned.
  - JAL/JALR are not counted. Both counters saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset: reset=1 for 2 cycles, release -> pc=0, flush=0; then 3 idle cycles -> pc=4, 8, 12.
- BEQ taken: pc=0x20, valid=1, branch=1, funct3=000, flag_igual=1, imm=0x40 -> next pc=0x60, flush=1 one cycle; following cycle pc=0x64, flush=0, and a valid branch in that cycle is ignored.
- BLTU vs BGE: funct3=110, flag_maior_igual_u=0 -> taken; funct3=101, flag_menor=1 -> not taken, pc+4, flush=0; funct3=010 -> never taken.
- JALR with priority: jalr=1, jal=1, alu_result=0x1235 -> pc=0x1234 (jalr wins, bit0 cleared); alu_result=0x1236 -> pc=0x100, misaligned=1 and flush=1 for one cycle.
- Stall and wrap: pc=64'hFFFFFFFFFFFFFFFC, stall=1 with a taken jal -> pc holds, flush=0; stall=0 with no instruction -> pc=0. Reset during FLUSH -> pc=RESET_VECTOR, state RUN, flush=0.
- Stats (BRANCH_PC_STATS_EN defined): 5 branches, 3 taken, 1 jal, 1 branch during stall -> branch_count=5, taken_count=3.
